// File: rtl/pudding_pkg.sv
// Shared types and constants for the thermometer sequencer blocks.
package pudding_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SLEW   = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    localparam int OUT_WIDTH_DEFAULT = 256;

    function automatic int code_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/level_to_thermo.sv
// Combinational binary level to thermometer decoder: bit i is set when i < level.
module level_to_thermo
    import pudding_pkg::*;
#(
    parameter int OUT_WIDTH = OUT_WIDTH_DEFAULT,
    parameter int CODE_W    = code_w(OUT_WIDTH)
) (
    input  logic [CODE_W-1:0]    level,
    output logic [OUT_WIDTH-1:0] thermo
);

    for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_cell
        assign thermo[i] = (CODE_W'(i) < level);
    end

endmodule

// File: rtl/thermo_seq_driver.sv
// Slew-limited, settle-timed thermometer code sequencer with registered outputs.
// Build option: define THERMO_SLEW_EN to limit each step to MAX_STEP cells.
module thermo_seq_driver
    import pudding_pkg::*;
#(
    parameter int OUT_WIDTH     = OUT_WIDTH_DEFAULT,
    parameter int CODE_W        = code_w(OUT_WIDTH),
    parameter int MAX_STEP      = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CODE_W-1:0]    in_code,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] thermo,
    output logic [CODE_W-1:0]    level,
    output logic                 busy
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DW    = CODE_W + 2;
`ifdef THERMO_SLEW_EN
    localparam int STEP_LIM = MAX_STEP;
`else
    // A step limit spanning the whole range makes SLEW finish in one edge.
    localparam int STEP_LIM = (MAX_STEP > OUT_WIDTH) ? MAX_STEP : OUT_WIDTH;
`endif
    localparam logic signed [DW-1:0] STEP_S   = DW'((STEP_LIM < OUT_WIDTH) ? STEP_LIM : OUT_WIDTH);
    localparam logic [CNT_W-1:0]     CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CODE_W-1:0]    LVL_MAX  = CODE_W'(OUT_WIDTH);

    function automatic logic [CODE_W-1:0] sat_code(input logic [CODE_W-1:0] c);
        return (c > LVL_MAX) ? LVL_MAX : c;
    endfunction

    state_e                 state_q, state_d;
    logic [CODE_W-1:0]      level_q, level_d;
    logic [CODE_W-1:0]      target_q, target_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   thermo_q, thermo_d;
    logic signed [DW-1:0]   lvl_s, diff_s, mag_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            thermo_q <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            thermo_q <= thermo_d;
        end
    end

    always_comb begin
        lvl_s  = $signed({2'b00, level_q});
        diff_s = $signed({2'b00, target_q}) - lvl_s;
        mag_s  = diff_s[DW-1] ? -diff_s : diff_s;

        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    target_d = sat_code(in_code);
                    state_d  = ST_SLEW;
                end
            end
            ST_SLEW: begin
                if (mag_s <= STEP_S) begin
                    level_d = target_q;
                    cnt_d   = CNT_INIT;
                    state_d = ST_SETTLE;
                end else begin
                    level_d = CODE_W'(diff_s[DW-1] ? lvl_s - STEP_S : lvl_s + STEP_S);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_IDLE) && !rst;
        busy     = (state_q != ST_IDLE);
    end

    // thermo is registered from the decode of the next level, never from level_q.
    level_to_thermo #(
        .OUT_WIDTH (OUT_WIDTH),
        .CODE_W    (CODE_W)
    ) u_decode (
        .level  (level_d),
        .thermo (thermo_d)
    );

    assign thermo = thermo_q;
    assign level  = level_q;

endmodule

// File: tb/tb_thermo_seq_driver.sv
// Scoreboard bench for thermo_seq_driver: driver queues expected events, monitor checks them.
module tb_thermo_seq_driver;

    typedef struct {
        int cyc;
        int lvl;
        bit rdy;
    } exp_t;

`ifdef THERMO_SLEW_EN
    localparam int STEP_CHK = 16;
`else
    localparam int STEP_CHK = 256;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [8:0]   in_code;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] thermo;
    logic [8:0]   level;
    logic         busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    logic [8:0]   prev_lvl;
    logic         prev_rdy;
    logic [255:0] prev_th;

    thermo_seq_driver dut (
        .clk      (clk),
        .rst      (rst),
        .in_code  (in_code),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .thermo   (thermo),
        .level    (level),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] dec(input int n);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int l, input bit r);
        exp_t e;
        e.cyc = c;
        e.lvl = l;
        e.rdy = r;
        sb.push_back(e);
    endtask

    task automatic send(input int code, input bit hold, output int a);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("accept_timeout", 256'(in_ready), 256'd1);
        in_code  = 9'(code);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int k;
        k = 0;
        while ((sb.size() != 0 || !in_ready) && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done_timeout", 256'(k < lim), 256'd1);
    endtask

    // Monitor: every level change or in_ready rise is an output event.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_lvl = level;
            prev_rdy = in_ready;
            prev_th  = thermo;
        end else begin
            if (level != prev_lvl || (in_ready && !prev_rdy)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event_level", 256'(level), 256'(prev_lvl));
                end else begin
                    e = sb.pop_front();
                    if (e.cyc >= 0) chk("event_cycle", 256'(cyc), 256'(e.cyc));
                    chk("level", 256'(level), 256'(e.lvl));
                    chk("thermo", thermo, dec(e.lvl));
                    chk("in_ready", 256'(in_ready), 256'(e.rdy));
                    chk("busy", 256'(busy), 256'(!e.rdy));
                end
                if (level != prev_lvl) begin
                    chk("step_size_ok", 256'($countones(prev_th ^ thermo) <= STEP_CHK), 256'd1);
                    chk("one_direction", 256'(((prev_th & ~thermo) == '0) || ((thermo & ~prev_th) == '0)), 256'd1);
                end
            end
            prev_lvl = level;
            prev_rdy = in_ready;
            prev_th  = thermo;
        end
    end

    initial begin
        int a;
        int b;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_code  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_thermo", thermo, '0);
        chk("rst_level", 256'(level), 256'd0);
        chk("rst_in_ready", 256'(in_ready), 256'd0);
        chk("rst_busy", 256'(busy), 256'd0);
        push(-1, 0, 1'b1);
        rst = 1'b0;
        wait_done(10);

        // Up-step 0 -> 40
        send(40, 1'b0, a);
`ifdef THERMO_SLEW_EN
        push(a + 1, 16, 1'b0);
        push(a + 2, 32, 1'b0);
        push(a + 3, 40, 1'b0);
        push(a + 7, 40, 1'b1);
`else
        push(a + 1, 40, 1'b0);
        push(a + 5, 40, 1'b1);
`endif
        wait_done(40);
        chk("thermo_40", thermo, dec(40));

        // Down-step 40 -> 0
        send(0, 1'b0, a);
`ifdef THERMO_SLEW_EN
        push(a + 1, 24, 1'b0);
        push(a + 2, 8, 1'b0);
        push(a + 3, 0, 1'b0);
        push(a + 7, 0, 1'b1);
`else
        push(a + 1, 0, 1'b0);
        push(a + 5, 0, 1'b1);
`endif
        wait_done(40);

        // Saturation: 300 clamps to 256
        send(300, 1'b0, a);
`ifdef THERMO_SLEW_EN
        for (int k = 1; k <= 16; k++) push(a + k, 16 * k, 1'b0);
        push(a + 20, 256, 1'b1);
`else
        push(a + 1, 256, 1'b0);
        push(a + 5, 256, 1'b1);
`endif
        wait_done(60);
        chk("thermo_full", thermo, {256{1'b1}});

        // Same level again: one idle SLEW edge then full SETTLE
        send(300, 1'b0, a);
        push(a + 5, 256, 1'b1);
        wait_done(40);

        // Backpressure: valid held, code changes while busy
        send(40, 1'b1, a);
`ifdef THERMO_SLEW_EN
        for (int k = 1; k <= 13; k++) push(a + k, 256 - 16 * k, 1'b0);
        push(a + 14, 40, 1'b0);
        push(a + 18, 40, 1'b1);
        b = a + 19;
        push(b + 1, 56, 1'b0);
        push(b + 2, 72, 1'b0);
        push(b + 3, 88, 1'b0);
        push(b + 4, 99, 1'b0);
        push(b + 8, 99, 1'b1);
`else
        push(a + 1, 40, 1'b0);
        push(a + 5, 40, 1'b1);
        b = a + 6;
        push(b + 1, 99, 1'b0);
        push(b + 5, 99, 1'b1);
`endif
        @(negedge clk);
        in_code = 9'd70;
        @(negedge clk);
        in_code = 9'd99;
        while (cyc < b) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_done(60);

        // Reset in the middle of a 99 -> 200 transition
        send(200, 1'b0, a);
`ifdef THERMO_SLEW_EN
        push(a + 1, 115, 1'b0);
        push(a + 2, 131, 1'b0);
`else
        push(a + 1, 200, 1'b0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_thermo", thermo, '0);
        chk("midrst_level", 256'(level), 256'd0);
        chk("midrst_busy", 256'(busy), 256'd0);
        chk("midrst_in_ready", 256'(in_ready), 256'd0);
        sb.delete();
        @(posedge clk);
        #1;
        push(-1, 0, 1'b1);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_level", 256'(level), 256'd0);
        chk("post_rst_busy", 256'(busy), 256'd0);
        chk("post_rst_in_ready", 256'(in_ready), 256'd1);

        chk("scoreboard_empty", 256'(sb.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
